// File: rtl/sap1_controller_sequencer_if.sv
// Controller <-> datapath signal bundle for the SAP-1 sequencer.
// master = controller side, slave = datapath / observer side.
interface sap1_controller_sequencer_if;
   logic [3:0] opcode;
   logic       run_mode;
   logic       step;
   logic       pc_increment;
   logic       pc_enable_output;
   logic       mar_enable_input;
   logic       ram_enable_output;
   logic       ir_enable_input;
   logic       ir_enable_output;
   logic       a_enable_input;
   logic       a_enable_output;
   logic       b_enable_input;
   logic       alu_subtract;
   logic       alu_enable_output;
   logic       out_enable_input;
   logic [5:0] t_state;
   logic       halted;
   logic [7:0] instr_count;

   modport master (
      input  opcode, run_mode, step,
      output pc_increment, pc_enable_output, mar_enable_input, ram_enable_output,
             ir_enable_input, ir_enable_output, a_enable_input, a_enable_output,
             b_enable_input, alu_subtract, alu_enable_output, out_enable_input,
             t_state, halted, instr_count
   );

   modport slave (
      output opcode, run_mode, step,
      input  pc_increment, pc_enable_output, mar_enable_input, ram_enable_output,
             ir_enable_input, ir_enable_output, a_enable_input, a_enable_output,
             b_enable_input, alu_subtract, alu_enable_output, out_enable_input,
             t_state, halted, instr_count
   );
endinterface

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control sequencer: 6-state ring counter, opcode decode, single-step,
// HALT latch and retired-instruction counter.
module sap1_controller_sequencer (
   input logic                         Clock,
   input logic                         Reset,
   sap1_controller_sequencer_if.master bus
);
   localparam logic [3:0] OP_LDA  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_OUT  = 4'b0100;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   logic [5:0] t_state_q, t_state_d;
   logic       halted_q, halted_d;
   logic [7:0] instr_count_q, instr_count_d;
   logic       step_q;
   logic       step_rise;
   logic       advance;
   logic       halt_now;
   logic       strobe_en;

   assign step_rise = bus.step & ~step_q;
   assign advance   = ~halted_q & (bus.run_mode | step_rise);
   assign halt_now  = advance & (t_state_q == T4) & (bus.opcode == OP_HALT);
   // Strobes must be quiet while Reset is asserted even though advance may be high.
   assign strobe_en = advance & ~Reset;

   always_comb begin
      t_state_d     = t_state_q;
      halted_d      = halted_q | halt_now;
      instr_count_d = instr_count_q;
      if (advance && !halt_now) begin
         t_state_d = {t_state_q[4:0], t_state_q[5]};
         if (t_state_q == T6) begin
            instr_count_d = instr_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         t_state_q     <= T1;
         halted_q      <= 1'b0;
         instr_count_q <= 8'd0;
         step_q        <= 1'b0;
      end else begin
         t_state_q     <= t_state_d;
         halted_q      <= halted_d;
         instr_count_q <= instr_count_d;
         step_q        <= bus.step;
      end
   end

   always_comb begin
      bus.pc_increment      = 1'b0;
      bus.pc_enable_output  = 1'b0;
      bus.mar_enable_input  = 1'b0;
      bus.ram_enable_output = 1'b0;
      bus.ir_enable_input   = 1'b0;
      bus.ir_enable_output  = 1'b0;
      bus.a_enable_input    = 1'b0;
      bus.a_enable_output   = 1'b0;
      bus.b_enable_input    = 1'b0;
      bus.alu_subtract      = 1'b0;
      bus.alu_enable_output = 1'b0;
      bus.out_enable_input  = 1'b0;
      if (strobe_en) begin
         case (t_state_q)
            T1: begin
               bus.pc_enable_output = 1'b1;
               bus.mar_enable_input = 1'b1;
            end
            T2: bus.pc_increment = 1'b1;
            T3: begin
               bus.ram_enable_output = 1'b1;
               bus.ir_enable_input   = 1'b1;
            end
            T4: begin
               if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                  bus.ir_enable_output = 1'b1;
                  bus.mar_enable_input = 1'b1;
               end else if (bus.opcode == OP_OUT) begin
                  bus.a_enable_output  = 1'b1;
                  bus.out_enable_input = 1'b1;
               end
            end
            T5: begin
               if (bus.opcode == OP_LDA) begin
                  bus.ram_enable_output = 1'b1;
                  bus.a_enable_input    = 1'b1;
               end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                  bus.ram_enable_output = 1'b1;
                  bus.b_enable_input    = 1'b1;
                  // Su raised early so the ALU result is settled by T6.
                  bus.alu_subtract      = (bus.opcode == OP_SUB);
               end
            end
            T6: begin
               if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                  bus.alu_enable_output = 1'b1;
                  bus.a_enable_input    = 1'b1;
                  bus.alu_subtract      = (bus.opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.t_state     = t_state_q;
   assign bus.halted      = halted_q;
   assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Self-checking bench for sap1_controller_sequencer: vector table, directed
// corner cases, a program run against a small datapath, and random stimulus.
`timescale 1ns/1ps
module tb_sap1_controller_sequencer;
   localparam logic [3:0] LDA = 4'b0001, ADD = 4'b0010, SUB = 4'b0011;
   localparam logic [3:0] OUTP = 4'b0100, HLT = 4'b1111, NOP7 = 4'b0111;
   // Strobe vector order: {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Lb,Su,Eu,Lo}
   localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
   localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
   localparam logic [11:0] LB = 12'h008, SU = 12'h004, EU = 12'h002, LO = 12'h001;

   typedef struct {
      logic       rm;
      logic       st;
      logic [3:0] op;
      int         t;
      logic [11:0] str;
      int         cnt;
   } vec_t;

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   logic rm_drv = 1'b0, step_drv = 1'b0, use_dp = 1'b0;
   logic [3:0] op_drv = 4'd0;
   int n_checks = 0, n_errors = 0;

   // Datapath model
   logic [7:0] ram [16];
   logic [3:0] pc, mar;
   logic [7:0] ir, a_reg, b_reg, out_reg, snap_bus;
   logic [11:0] snap_str;
   logic [7:0] outs [$];

   sap1_controller_sequencer_if bif ();
   sap1_controller_sequencer dut (.Clock(Clock), .Reset(Reset), .bus(bif));

   always #5 Clock = ~Clock;

   assign bif.run_mode = rm_drv;
   assign bif.step     = step_drv;
   assign bif.opcode   = use_dp ? ir[7:4] : op_drv;

   function automatic logic [11:0] strobes();
      return {bif.pc_increment, bif.pc_enable_output, bif.mar_enable_input,
              bif.ram_enable_output, bif.ir_enable_input, bif.ir_enable_output,
              bif.a_enable_input, bif.a_enable_output, bif.b_enable_input,
              bif.alu_subtract, bif.alu_enable_output, bif.out_enable_input};
   endfunction

   function automatic int drivers();
      return $countones({bif.pc_enable_output, bif.ram_enable_output, bif.ir_enable_output,
                         bif.a_enable_output, bif.alu_enable_output});
   endfunction

   function automatic logic [11:0] exp_dec(int t, logic [3:0] op);
      case (t)
         1: return EP | LM;
         2: return CP;
         3: return CE | LI;
         4: return (op == LDA || op == ADD || op == SUB) ? (EI | LM) :
                   (op == OUTP) ? (EA | LO) : 12'h0;
         5: return (op == LDA) ? (CE | LA) : (op == ADD) ? (CE | LB) :
                   (op == SUB) ? (CE | LB | SU) : 12'h0;
         6: return (op == ADD) ? (EU | LA) : (op == SUB) ? (SU | EU | LA) : 12'h0;
         default: return 12'h0;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge Clock);
      #1 Reset = 1'b1;
      #2 Reset = 1'b0;
   endtask

   always @(negedge Clock) begin
      snap_str = strobes();
      snap_bus = bif.pc_enable_output  ? {4'h0, pc} :
                 bif.ram_enable_output ? ram[mar] :
                 bif.ir_enable_output  ? {4'h0, ir[3:0]} :
                 bif.a_enable_output   ? a_reg :
                 bif.alu_enable_output ? (bif.alu_subtract ? a_reg - b_reg : a_reg + b_reg) :
                 8'h00;
   end

   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pc <= '0; mar <= '0; ir <= '0; a_reg <= '0; b_reg <= '0; out_reg <= '0;
      end else if (use_dp) begin
         if ((snap_str & CP) != 0) pc <= pc + 4'd1;
         if ((snap_str & LM) != 0) mar <= snap_bus[3:0];
         if ((snap_str & LI) != 0) ir <= snap_bus;
         if ((snap_str & LA) != 0) a_reg <= snap_bus;
         if ((snap_str & LB) != 0) b_reg <= snap_bus;
         if ((snap_str & LO) != 0) begin
            out_reg <= snap_bus;
            outs.push_back(snap_bus);
         end
      end
   end

   initial begin
      vec_t vecs [19];
      logic [5:0] prev_t;
      int adv_cnt, cp_cnt, m_t, m_cnt, cyc;
      logic m_halt, m_prev_step, r_rm, r_st, adv;
      logic [3:0] r_op;
      logic step_seq [20];

      // ---- table: LDA, SUB, OUT back to back in free-run ----
      vecs[0]  = '{1'b1, 1'b0, LDA,  1, EP | LM, 0};
      vecs[1]  = '{1'b1, 1'b0, LDA,  2, CP, 0};
      vecs[2]  = '{1'b1, 1'b0, LDA,  3, CE | LI, 0};
      vecs[3]  = '{1'b1, 1'b0, LDA,  4, EI | LM, 0};
      vecs[4]  = '{1'b1, 1'b0, LDA,  5, CE | LA, 0};
      vecs[5]  = '{1'b1, 1'b0, LDA,  6, 12'h0, 0};
      vecs[6]  = '{1'b1, 1'b0, SUB,  1, EP | LM, 1};
      vecs[7]  = '{1'b1, 1'b0, SUB,  2, CP, 1};
      vecs[8]  = '{1'b1, 1'b0, SUB,  3, CE | LI, 1};
      vecs[9]  = '{1'b1, 1'b0, SUB,  4, EI | LM, 1};
      vecs[10] = '{1'b1, 1'b0, SUB,  5, CE | LB | SU, 1};
      vecs[11] = '{1'b1, 1'b0, SUB,  6, SU | EU | LA, 1};
      vecs[12] = '{1'b1, 1'b0, OUTP, 1, EP | LM, 2};
      vecs[13] = '{1'b1, 1'b0, OUTP, 2, CP, 2};
      vecs[14] = '{1'b1, 1'b0, OUTP, 3, CE | LI, 2};
      vecs[15] = '{1'b1, 1'b0, OUTP, 4, EA | LO, 2};
      vecs[16] = '{1'b1, 1'b0, OUTP, 5, 12'h0, 2};
      vecs[17] = '{1'b1, 1'b0, OUTP, 6, 12'h0, 2};
      vecs[18] = '{1'b0, 1'b0, OUTP, 1, 12'h0, 3};

      rm_drv = 1'b1; op_drv = LDA;
      do_reset();
      check("reset_t_state", int'(bif.t_state), 1);
      check("reset_count", int'(bif.instr_count), 0);
      check("reset_halted", int'(bif.halted), 0);
      foreach (vecs[i]) begin
         rm_drv = vecs[i].rm; step_drv = vecs[i].st; op_drv = vecs[i].op;
         @(negedge Clock);
         check($sformatf("vec%0d_t_state", i), int'(bif.t_state), 1 << (vecs[i].t - 1));
         check($sformatf("vec%0d_strobes", i), int'(strobes()), int'(vecs[i].str));
         check($sformatf("vec%0d_count", i), int'(bif.instr_count), vecs[i].cnt);
         check($sformatf("vec%0d_one_driver", i), int'(drivers() <= 1), 1);
         @(posedge Clock); #1;
      end

      // ---- async reset in the middle of T5 of an ADD ----
      rm_drv = 1'b1; op_drv = LDA;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i == 6) op_drv = ADD;
         @(posedge Clock);
      end
      #2;
      check("pre_reset_t5", int'(bif.t_state), 6'b010000);
      check("pre_reset_count", int'(bif.instr_count), 1);
      Reset = 1'b1;
      #1;
      check("async_reset_t_state", int'(bif.t_state), 1);
      check("async_reset_strobes", int'(strobes()), 0);
      check("async_reset_count", int'(bif.instr_count), 0);
      check("async_reset_halted", int'(bif.halted), 0);
      #1 Reset = 1'b0;

      // ---- single-step: step high 10 cycles, then three 0->1 pulses ----
      rm_drv = 1'b0; step_drv = 1'b0; op_drv = LDA;
      do_reset();
      for (int i = 0; i < 20; i++) step_seq[i] = 1'b0;
      for (int i = 0; i < 10; i++) step_seq[i] = 1'b1;
      step_seq[11] = 1'b1; step_seq[13] = 1'b1; step_seq[15] = 1'b1;
      adv_cnt = 0; cp_cnt = 0; prev_t = 6'b000001;
      for (int i = 0; i < 20; i++) begin
         step_drv = step_seq[i];
         @(negedge Clock);
         if (bif.t_state != prev_t) adv_cnt++;
         prev_t = bif.t_state;
         if (bif.pc_increment) cp_cnt++;
         @(posedge Clock); #1;
      end
      check("step_advances", adv_cnt, 4);
      check("step_final_t5", int'(bif.t_state), 6'b010000);
      check("step_cp_cycles", cp_cnt, 1);

      // ---- undefined opcode as NOP, then count wrap ----
      rm_drv = 1'b1; step_drv = 1'b0; op_drv = NOP7;
      do_reset();
      for (int t = 1; t <= 6; t++) begin
         @(negedge Clock);
         check($sformatf("nop_t%0d_strobes", t), int'(strobes()), int'(exp_dec(t, NOP7)));
         @(posedge Clock); #1;
      end
      check("nop_count", int'(bif.instr_count), 1);
      check("nop_back_t1", int'(bif.t_state), 1);
      repeat (255 * 6) @(posedge Clock);
      #1;
      check("nop_wrap_count", int'(bif.instr_count), 0);
      check("nop_wrap_t1", int'(bif.t_state), 1);

      // ---- full program against datapath model ----
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
      ram[0] = 8'h1D; ram[1] = 8'h40; ram[2] = 8'h2E; ram[3] = 8'h40;
      ram[4] = 8'h3F; ram[5] = 8'h40; ram[6] = 8'hF0;
      ram[13] = 8'd8; ram[14] = 8'd5; ram[15] = 8'd4;
      outs.delete();
      use_dp = 1'b1; rm_drv = 1'b1;
      do_reset();
      cyc = 0;
      while (!bif.halted && cyc < 100) begin
         @(negedge Clock);
         check("prog_one_driver", int'(drivers() <= 1), 1);
         @(posedge Clock); #1;
         cyc++;
      end
      check("prog_halted_in_time", int'(bif.halted), 1);
      check("prog_halt_cycles", cyc, 40);
      check("prog_halt_t4", int'(bif.t_state), 6'b001000);
      check("prog_count", int'(bif.instr_count), 6);
      check("prog_out_n", outs.size(), 3);
      if (outs.size() == 3) begin
         check("prog_out0", int'(outs[0]), 8);
         check("prog_out1", int'(outs[1]), 13);
         check("prog_out2", int'(outs[2]), 9);
      end
      for (int i = 0; i < 20; i++) begin
         step_drv = i[0];
         @(negedge Clock);
         check("halt_strobes_quiet", int'(strobes()), 0);
         @(posedge Clock); #1;
      end
      check("halt_hold_t4", int'(bif.t_state), 6'b001000);
      use_dp = 1'b0;

      // ---- random stimulus against a T-number / counter model ----
      m_t = 1; m_cnt = 0; m_halt = 1'b0; m_prev_step = 1'b0;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if (i % 120 == 119) begin
            do_reset();
            m_t = 1; m_cnt = 0; m_halt = 1'b0; m_prev_step = 1'b0;
         end
         r_rm = ($urandom_range(0, 3) == 0);
         r_st = $urandom_range(0, 1);
         r_op = 4'($urandom_range(0, 15));
         rm_drv = r_rm; step_drv = r_st; op_drv = r_op;
         adv = !m_halt && (r_rm || (r_st && !m_prev_step));
         @(negedge Clock);
         check("rand_t_state", int'(bif.t_state), 1 << (m_t - 1));
         check("rand_halted", int'(bif.halted), int'(m_halt));
         check("rand_count", int'(bif.instr_count), m_cnt);
         check("rand_strobes", int'(strobes()), adv ? int'(exp_dec(m_t, r_op)) : 0);
         check("rand_one_driver", int'(drivers() <= 1), 1);
         @(posedge Clock); #1;
         m_prev_step = r_st;
         if (adv) begin
            if (m_t == 4 && r_op == HLT) m_halt = 1'b1;
            else begin
               if (m_t == 6) m_cnt = (m_cnt + 1) % 256;
               m_t = (m_t % 6) + 1;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
